aes_spi_ctrl: RTL and testbench

//  Parametrised command controller between the SPI slave frame port and the AES key-expansion
//  and cipher cores. Handles key-reuse sessions (one key load, many data blocks) and per-block

---
 rtl/aes_spi_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_aes_spi_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_ctrl.sv
// Command controller between the SPI frame port and the AES key-expansion and
// cipher cores. Supports key-reuse sessions, per-block encrypt/decrypt and
// sticky busy/overrun/timeout/mode/no-key error reporting.
module aes_spi_ctrl #(
  parameter int KEY_W   = 256,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 64,
  parameter int ENC_EN  = 1,
  parameter int DEC_EN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [KEY_W+1:0] rx_frame,
  output logic             ke_start,
  output logic [3:0]       ke_nk,
  output logic [3:0]       ke_nr,
  output logic [KEY_W-1:0] ke_key,
  input  logic             ke_done,
  output logic             cr_start,
  output logic             cr_encrypt,
  output logic [BLK_W-1:0] cr_din,
  input  logic             cr_done,
  input  logic [BLK_W-1:0] cr_dout,
  output logic [BLK_W-1:0] tx_data,
  output logic             tx_load,
  output logic             busy,
  output logic [7:0]       status,
  output logic [7:0]       blk_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_NOKEY, S_EXPAND, S_READY, S_CRYPT} state_t;

  state_t           state, state_next;
  logic [TW-1:0]    timer;
  logic             key_valid, err_nokey, err_mode, err_ovr, err_tmo;
  logic [1:0]       key_sz;

  logic [1:0]       opcode;
  logic [KEY_W-1:0] payload;
  logic             is_data, mode, mode_ok, expired;
  logic [3:0]       nk_sel, nr_sel;
  logic             acc_key, acc_data, op_done, op_tmo;
  logic             set_nokey, set_mode, set_ovr;

  assign opcode  = rx_frame[KEY_W+1:KEY_W];
  assign payload = rx_frame[KEY_W-1:0];
  assign is_data = (opcode == 2'b11);
  assign mode    = payload[KEY_W-1];
  assign mode_ok = mode ? (ENC_EN != 0) : (DEC_EN != 0);
  assign expired = (timer == TW'(TIMEOUT - 1));

  assign busy   = (state == S_EXPAND) || (state == S_CRYPT);
  assign status = {key_valid, busy, err_nokey, err_mode, err_ovr, err_tmo, key_sz};

  // Key-size opcode to round-key parameters.
  always_comb begin
    nk_sel = 4'd8;
    nr_sel = 4'd14;
    case (opcode)
      2'b00:   begin nk_sel = 4'd4; nr_sel = 4'd10; end
      2'b01:   begin nk_sel = 4'd6; nr_sel = 4'd12; end
      default: begin nk_sel = 4'd8; nr_sel = 4'd14; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_NOKEY;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle event strobes for the datapath.
  always_comb begin
    state_next = state;
    acc_key    = 1'b0;
    acc_data   = 1'b0;
    op_done    = 1'b0;
    op_tmo     = 1'b0;
    set_nokey  = 1'b0;
    set_mode   = 1'b0;
    set_ovr    = 1'b0;
    case (state)
      S_NOKEY, S_READY: begin
        if (rx_valid) begin
          if (!is_data) begin
            acc_key    = 1'b1;
            state_next = S_EXPAND;
          end else if (state == S_NOKEY) begin
            set_nokey = 1'b1;
          end else if (!mode_ok) begin
            set_mode = 1'b1;
          end else begin
            acc_data   = 1'b1;
            state_next = S_CRYPT;
          end
        end
      end
      S_EXPAND: begin
        set_ovr = rx_valid;
        if (ke_done) begin
          op_done    = 1'b1;
          state_next = S_READY;
        end else if (expired) begin
          op_tmo     = 1'b1;
          state_next = S_NOKEY;
        end
      end
      S_CRYPT: begin
        set_ovr = rx_valid;
        if (cr_done) begin
          op_done    = 1'b1;
          state_next = S_READY;
        end else if (expired) begin
          op_tmo     = 1'b1;
          state_next = S_NOKEY;
        end
      end
      default: state_next = S_NOKEY;
    endcase
  end

  // Latches, pulses, sticky errors, block counter and wait timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      ke_start   <= 1'b0;
      ke_nk      <= '0;
      ke_nr      <= '0;
      ke_key     <= '0;
      cr_start   <= 1'b0;
      cr_encrypt <= 1'b0;
      cr_din     <= '0;
      tx_data    <= '0;
      tx_load    <= 1'b0;
      blk_cnt    <= '0;
      key_valid  <= 1'b0;
      key_sz     <= '0;
      err_nokey  <= 1'b0;
      err_mode   <= 1'b0;
      err_ovr    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      ke_start <= acc_key;
      cr_start <= acc_data;
      tx_load  <= 1'b0;
      // Timer restarts on every state change so each wait state counts from 0.
      timer    <= (busy && state_next == state) ? timer + TW'(1) : '0;
      if (set_nokey) err_nokey <= 1'b1;
      if (set_mode)  err_mode  <= 1'b1;
      if (set_ovr)   err_ovr   <= 1'b1;
      if (op_tmo)    err_tmo   <= 1'b1;
      if (acc_key) begin
        ke_key    <= payload;
        ke_nk     <= nk_sel;
        ke_nr     <= nr_sel;
        key_sz    <= opcode;
        key_valid <= 1'b0;
        blk_cnt   <= '0;
        err_nokey <= 1'b0;
        err_mode  <= 1'b0;
        err_ovr   <= 1'b0;
        err_tmo   <= 1'b0;
      end
      if (acc_data) begin
        cr_din     <= payload[BLK_W-1:0];
        cr_encrypt <= mode;
      end
      if (state == S_EXPAND && op_done) key_valid <= 1'b1;
      if (state == S_CRYPT && op_done) begin
        tx_data <= cr_dout;
        tx_load <= 1'b1;
        blk_cnt <= blk_cnt + 8'd1;
      end
      if (state == S_CRYPT && op_tmo) key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Self-checking bench for aes_spi_ctrl: directed sequences, a key-size table,
// randomized transactions against a transaction-level model, and a DEC_EN=0 build.
module tb_aes_spi_ctrl;

  localparam int KW  = 256;
  localparam int BW  = 128;
  localparam int TMO = 64;

  logic clk;
  logic rst_n, rx_valid, ke_done, cr_done;
  logic [KW+1:0] rx_frame;
  logic [BW-1:0] cr_dout;
  logic ke_start, cr_start, cr_encrypt, tx_load, busy;
  logic [3:0] ke_nk, ke_nr;
  logic [KW-1:0] ke_key;
  logic [BW-1:0] cr_din, tx_data;
  logic [7:0] status, blk_cnt;

  logic rst_n_b, rx_valid_b, ke_done_b, cr_done_b;
  logic [KW+1:0] rx_frame_b;
  logic [BW-1:0] cr_dout_b;
  logic ke_start_b, cr_start_b, cr_encrypt_b, tx_load_b, busy_b;
  logic [3:0] ke_nk_b, ke_nr_b;
  logic [KW-1:0] ke_key_b;
  logic [BW-1:0] cr_din_b, tx_data_b;
  logic [7:0] status_b, blk_cnt_b;

  aes_spi_ctrl #(.KEY_W(KW), .BLK_W(BW), .TIMEOUT(TMO), .ENC_EN(1), .DEC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_frame(rx_frame),
    .ke_start(ke_start), .ke_nk(ke_nk), .ke_nr(ke_nr), .ke_key(ke_key), .ke_done(ke_done),
    .cr_start(cr_start), .cr_encrypt(cr_encrypt), .cr_din(cr_din), .cr_done(cr_done),
    .cr_dout(cr_dout), .tx_data(tx_data), .tx_load(tx_load), .busy(busy),
    .status(status), .blk_cnt(blk_cnt));

  aes_spi_ctrl #(.KEY_W(KW), .BLK_W(BW), .TIMEOUT(TMO), .ENC_EN(1), .DEC_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rx_valid(rx_valid_b), .rx_frame(rx_frame_b),
    .ke_start(ke_start_b), .ke_nk(ke_nk_b), .ke_nr(ke_nr_b), .ke_key(ke_key_b),
    .ke_done(ke_done_b), .cr_start(cr_start_b), .cr_encrypt(cr_encrypt_b),
    .cr_din(cr_din_b), .cr_done(cr_done_b), .cr_dout(cr_dout_b), .tx_data(tx_data_b),
    .tx_load(tx_load_b), .busy(busy_b), .status(status_b), .blk_cnt(blk_cnt_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: READY exactly when a key is valid, NOKEY otherwise.
  logic       m_kv, m_nokey, m_mode, m_ovr, m_tmo;
  logic [1:0] m_sz;
  int         m_cnt;
  logic [BW-1:0] m_tx;

  typedef struct {
    logic [1:0] op;
    logic [3:0] nk;
    logic [3:0] nr;
  } ksz_t;
  ksz_t ktab[3];

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand256();
    logic [KW-1:0] r;
    for (int i = 0; i < KW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] m_status();
    return {m_kv, 1'b0, m_nokey, m_mode, m_ovr, m_tmo, m_sz};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".status"}, KW'(status), KW'(m_status()));
    chk({tag, ".blk_cnt"}, KW'(blk_cnt), KW'(m_cnt[7:0]));
    chk({tag, ".tx_data"}, KW'(tx_data), KW'(m_tx));
    chk({tag, ".busy"}, KW'(busy), KW'(0));
  endtask

  task automatic send(input logic [1:0] op, input logic [KW-1:0] pl);
    rx_frame = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Run one wait state; done arrives at wait cycle d (never if d >= TMO),
  // optional overrun frame at wait cycle ovr_at.
  task automatic wait_op(input bit is_key, input int d, input int ovr_at,
                         input logic [BW-1:0] dout, output bit ok);
    logic [KW-1:0] junk;
    ok = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      chk("wait.busy", KW'(busy), KW'(1));
      if (c > 0) chk("wait.start", KW'(is_key ? ke_start : cr_start), KW'(0));
      chk("wait.tx_load", KW'(tx_load), KW'(0));
      ke_done = is_key && (c == d);
      cr_done = !is_key && (c == d);
      cr_dout = dout;
      if (c == ovr_at) begin
        junk = rand256();
        rx_frame = {2'($urandom), junk};
        rx_valid = 1'b1;
        m_ovr = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      ke_done = 1'b0;
      cr_done = 1'b0;
      if (c == d) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic [KW-1:0] key,
                         input int d, input int ovr_at);
    bit ok;
    send(sz, key);
    m_sz = sz; m_kv = 0; m_nokey = 0; m_mode = 0; m_ovr = 0; m_tmo = 0; m_cnt = 0;
    chk("load.ke_start", KW'(ke_start), KW'(1));
    chk("load.ke_nk", KW'(ke_nk), KW'(4 + 2 * int'(sz)));
    chk("load.ke_nr", KW'(ke_nr), KW'(10 + 2 * int'(sz)));
    chk("load.ke_key", ke_key, key);
    chk("load.status", KW'(status), KW'({m_status() | 8'h40}));
    wait_op(1'b1, d, ovr_at, '0, ok);
    if (ok) m_kv = 1'b1;
    else    m_tmo = 1'b1;
    chk("load.ke_start_end", KW'(ke_start), KW'(0));
    check_idle("load");
  endtask

  task automatic do_data(input logic mode, input logic [BW-1:0] blk,
                         input logic [BW-1:0] dout, input int d, input int ovr_at);
    bit ok;
    logic [KW-1:0] fill;
    fill = rand256();
    send(2'b11, {mode, fill[KW-BW-2:0], blk});
    if (!m_kv) begin
      m_nokey = 1'b1;
      chk("nokey.cr_start", KW'(cr_start), KW'(0));
      check_idle("nokey");
      return;
    end
    chk("data.cr_start", KW'(cr_start), KW'(1));
    chk("data.cr_encrypt", KW'(cr_encrypt), KW'(mode));
    chk("data.cr_din", KW'(cr_din), KW'(blk));
    wait_op(1'b0, d, ovr_at, dout, ok);
    if (ok) begin
      chk("data.tx_load", KW'(tx_load), KW'(1));
      chk("data.tx_data", KW'(tx_data), KW'(dout));
      m_tx = dout;
      m_cnt = (m_cnt + 1) % 256;
      @(negedge clk);
      chk("data.tx_load_once", KW'(tx_load), KW'(0));
    end else begin
      m_tmo = 1'b1;
      m_kv = 1'b0;
      chk("tmo.tx_load", KW'(tx_load), KW'(0));
    end
    check_idle("data");
  endtask

  task automatic stray_done();
    ke_done = 1'b1;
    cr_done = 1'b1;
    cr_dout = BW'(rand256());
    @(negedge clk);
    ke_done = 1'b0;
    cr_done = 1'b0;
    chk("stray.tx_load", KW'(tx_load), KW'(0));
    check_idle("stray");
  endtask

  localparam logic [KW-1:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [BW-1:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    clk = 0;
    rst_n = 0; rx_valid = 0; ke_done = 0; cr_done = 0; rx_frame = '0; cr_dout = '0;
    rst_n_b = 0; rx_valid_b = 0; ke_done_b = 0; cr_done_b = 0; rx_frame_b = '0; cr_dout_b = '0;
    m_kv = 0; m_nokey = 0; m_mode = 0; m_ovr = 0; m_tmo = 0; m_sz = 0; m_cnt = 0; m_tx = '0;
    ktab[0] = '{2'b00, 4'd4, 4'd10};
    ktab[1] = '{2'b01, 4'd6, 4'd12};
    ktab[2] = '{2'b10, 4'd8, 4'd14};

    repeat (2) @(negedge clk);
    chk("rst.status", KW'(status), KW'(0));
    chk("rst.outs", KW'({ke_start, cr_start, tx_load, busy, cr_encrypt, ke_nk, ke_nr, blk_cnt}), KW'(0));
    chk("rst.ke_key", ke_key, '0);
    chk("rst.data", KW'({cr_din, tx_data}), KW'(0));
    rst_n = 1; rst_n_b = 1;
    @(negedge clk);

    // DATA with no key loaded.
    do_data(1'b1, C3_PT, '0, 3, -1);

    // Key-size table.
    for (int i = 0; i < 3; i++) begin
      do_load(ktab[i].op, rand256(), 5, -1);
      chk("ktab.nk", KW'(ke_nk), KW'(ktab[i].nk));
      chk("ktab.nr", KW'(ke_nr), KW'(ktab[i].nr));
      chk("ktab.sz", KW'(status[1:0]), KW'(ktab[i].op));
    end

    // FIPS-197 C.3 session: three decrypts.
    do_load(2'b10, C3_KEY, 20, -1);
    chk("c3.nk", KW'(ke_nk), KW'(8));
    chk("c3.nr", KW'(ke_nr), KW'(14));
    chk("c3.kv", KW'(status[7]), KW'(1));
    for (int i = 0; i < 3; i++) begin
      do_data(1'b0, C3_CT, C3_PT, 15, -1);
      chk("c3.tx", KW'(tx_data), KW'(C3_PT));
    end
    chk("c3.blk_cnt", KW'(blk_cnt), KW'(3));

    // Overrun during a block; block still completes.
    do_data(1'b1, C3_PT, C3_CT, 15, 5);
    chk("ovr.err", KW'(status[3]), KW'(1));

    // Cipher timeout, then rekey clears it.
    do_data(1'b0, C3_CT, C3_PT, 1000, -1);
    chk("tmo.err", KW'(status[2]), KW'(1));
    chk("tmo.kv", KW'(status[7]), KW'(0));
    do_data(1'b0, C3_CT, C3_PT, 2, -1);
    do_load(2'b00, rand256(), 3, -1);
    chk("tmo.cleared", KW'(status[2]), KW'(0));

    // Expansion: done in the expiry cycle wins; one cycle later is a timeout.
    do_load(2'b01, rand256(), TMO - 1, -1);
    chk("edge.kv", KW'(status[7]), KW'(1));
    do_load(2'b01, rand256(), TMO, -1);
    chk("edge.tmo", KW'(status[2]), KW'(1));
    stray_done();

    // Block counter wrap.
    do_load(2'b10, C3_KEY, 1, -1);
    stray_done();
    for (int i = 0; i < 256; i++) do_data(1'($urandom), BW'(rand256()), BW'(rand256()), 0, -1);
    chk("wrap.blk_cnt", KW'(blk_cnt), KW'(0));

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      int r, d, ov;
      r = $urandom_range(0, 9);
      d = ($urandom_range(0, 7) == 0) ? TMO + 2 : $urandom_range(0, 30);
      ov = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (d < TMO) ? d : TMO - 1) : -1;
      if (r < 2)      do_load(2'($urandom_range(0, 2)), rand256(), d, ov);
      else if (r < 9) do_data(1'($urandom), BW'(rand256()), BW'(rand256()), d, ov);
      else            stray_done();
    end

    // DEC_EN=0 build.
    rx_frame_b = {2'b00, C3_KEY};
    rx_valid_b = 1;
    @(negedge clk);
    rx_valid_b = 0;
    chk("b.ke_start", KW'(ke_start_b), KW'(1));
    chk("b.nk", KW'(ke_nk_b), KW'(4));
    ke_done_b = 1;
    @(negedge clk);
    ke_done_b = 0;
    chk("b.kv", KW'(status_b), KW'(8'h80));
    rx_frame_b = {2'b11, 1'b0, 127'd0, C3_CT};
    rx_valid_b = 1;
    @(negedge clk);
    rx_valid_b = 0;
    chk("b.dec_start", KW'(cr_start_b), KW'(0));
    chk("b.err_mode", KW'(status_b), KW'(8'h90));
    rx_frame_b = {2'b11, 1'b1, 127'd0, C3_PT};
    rx_valid_b = 1;
    @(negedge clk);
    rx_valid_b = 0;
    chk("b.enc_start", KW'({cr_start_b, cr_encrypt_b, busy_b}), KW'(3'b111));
    cr_done_b = 1;
    cr_dout_b = C3_CT;
    @(negedge clk);
    cr_done_b = 0;
    chk("b.tx", KW'({tx_load_b, tx_data_b}), KW'({1'b1, C3_CT}));
    rx_frame_b = {2'b01, C3_KEY};
    rx_valid_b = 1;
    @(negedge clk);
    rx_valid_b = 0;
    chk("b.rekey", KW'(status_b), KW'(8'h41));
    repeat (3) @(negedge clk);
    #2 rst_n_b = 0;
    #1;
    chk("b.rst.status", KW'(status_b), KW'(0));
    chk("b.rst.outs", KW'({ke_start_b, cr_start_b, tx_load_b, busy_b, cr_encrypt_b,
                           ke_nk_b, ke_nr_b, blk_cnt_b}), KW'(0));
    chk("b.rst.key", ke_key_b, '0);
    chk("b.rst.data", KW'({cr_din_b, tx_data_b}), KW'(0));
    @(negedge clk);
    chk("b.rst.held", KW'({ke_start_b, status_b}), KW'(0));
    rst_n_b = 1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
